vector_execute_unit: RTL and testbench



---
 rtl/vec_pkg.sv | 38 +++
 rtl/vector_execute_unit_if.sv | 30 +++
 rtl/vector_execute_unit_sbox.sv | 26 ++
 rtl/vector_execute_unit.sv | 130 +++++++++++++
 tb/tb_vector_execute_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_pkg.sv
// Shared types, sizing constants and word-level helpers for the vector execute unit.
package vec_pkg;

    localparam int VEC_W   = 256;
    localparam int LANES_N = 4;
    localparam int REG_AW  = 5;
    localparam int BYTES   = VEC_W / 8;
    localparam int ITER    = BYTES / LANES_N;

    typedef enum logic [2:0] {
        VXOR  = 3'b000,
        VADD8 = 3'b001,
        VSUB  = 3'b010,
        VROT  = 3'b011,
        VMOV  = 3'b100
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [31:0] rotword(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Lane-wise add: each byte wraps on its own, no carry crosses a byte boundary.
    function automatic logic [31:0] add8x4(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s[i*8 +: 8] = x[i*8 +: 8] + y[i*8 +: 8];
        end
        return s;
    endfunction

endpackage

// File: rtl/vector_execute_unit_if.sv
// Execute-stage bundle between the D/E register, the vector unit and the hazard unit.
interface vector_execute_unit_if
    import vec_pkg::*;
#(
    parameter int V = VEC_W,
    parameter int R = REG_AW
);
    logic         flush;
    logic         start;
    logic [2:0]   op;
    logic [V-1:0] a;
    logic [V-1:0] b;
    logic [R-1:0] wa;
    logic         regwrite;
    logic         stall;
    logic         valid;
    logic [V-1:0] result;
    logic [R-1:0] wa_out;
    logic         regwrite_out;

    modport master (
        output flush, start, op, a, b, wa, regwrite,
        input  stall, valid, result, wa_out, regwrite_out
    );

    modport slave (
        input  flush, start, op, a, b, wa, regwrite,
        output stall, valid, result, wa_out, regwrite_out
    );
endinterface

// File: rtl/vector_execute_unit_sbox.sv
// AES forward S-box, one byte in, one byte out, purely combinational.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = SBOX[din];
endmodule

// File: rtl/vector_execute_unit.sv
// Vector execute stage: single-cycle lane ops in IDLE, SubBytes swept LANES bytes per
// cycle in RUN while stalling the front of the pipe, result presented in DONE.
module vector_execute_unit
    import vec_pkg::*;
#(
    parameter int V     = VEC_W,
    parameter int LANES = LANES_N,
    parameter int R     = REG_AW
)(
    input  logic                  clk,
    input  logic                  rst,
    vector_execute_unit_if.slave  bus
);
    localparam int NBYTES = V / 8;
    localparam int NITER  = NBYTES / LANES;
    localparam int CW     = (NITER > 1) ? $clog2(NITER) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [V-1:0]  src;
    logic [V-1:0]  acc;
    logic [V-1:0]  alu_result;
    logic [R-1:0]  wa_q;
    logic          rw_q;
    logic [7:0]    lane_in  [LANES];
    logic [7:0]    lane_out [LANES];
    op_t           opc;
    logic          kill;

    assign opc  = op_t'(bus.op);
    assign kill = rst | bus.flush;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_in[l] = src[(int'(cnt) * LANES + l) * 8 +: 8];
        aes_sbox u_sbox (
            .din  (lane_in[l]),
            .dout (lane_out[l])
        );
    end

    always_comb begin
        alu_result = '0;
        case (opc)
            VXOR:  alu_result = bus.a ^ bus.b;
            VADD8: for (int w = 0; w < V / 32; w++) begin
                       alu_result[w*32 +: 32] = add8x4(bus.a[w*32 +: 32], bus.b[w*32 +: 32]);
                   end
            VROT:  for (int w = 0; w < V / 32; w++) begin
                       alu_result[w*32 +: 32] = rotword(bus.a[w*32 +: 32]);
                   end
            VMOV:  alu_result = bus.b;
            default: alu_result = '0;
        endcase
    end

    // A flush or reset kills whatever would leave E this cycle; the stall stays Moore in RUN.
    always_comb begin
        bus.stall        = 1'b0;
        bus.valid        = 1'b0;
        bus.result       = '0;
        bus.wa_out       = bus.wa;
        bus.regwrite_out = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !kill) begin
                    if (opc == VSUB) begin
                        bus.stall = 1'b1;
                    end else begin
                        bus.valid        = 1'b1;
                        bus.result       = alu_result;
                        bus.regwrite_out = bus.regwrite;
                    end
                end
            end
            RUN: begin
                bus.stall  = 1'b1;
                bus.wa_out = wa_q;
            end
            DONE: begin
                bus.wa_out = wa_q;
                if (!kill) begin
                    bus.valid        = 1'b1;
                    bus.result       = acc;
                    bus.regwrite_out = rw_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            src   <= '0;
            acc   <= '0;
            wa_q  <= '0;
            rw_q  <= 1'b0;
        end else if (bus.flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && opc == VSUB) begin
                        src   <= bus.a;
                        wa_q  <= bus.wa;
                        rw_q  <= bus.regwrite;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        acc[(int'(cnt) * LANES + l) * 8 +: 8] <= lane_out[l];
                    end
                    if (cnt == CW'(NITER - 1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // DONE ignores start: the same instruction is still sitting in E.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_execute_unit.sv
// Scoreboard bench for vector_execute_unit; S-box reference built from GF(2^8) inversion.
module tb_vector_execute_unit;
    import vec_pkg::*;

    localparam int V = 256;
    localparam int R = 5;

    typedef struct {
        logic [V-1:0] result;
        logic [R-1:0] wa;
        logic         rw;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    vector_execute_unit_if #(.V(V), .R(R)) bus_if ();

    vector_execute_unit #(.V(V), .LANES(4), .R(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [V-1:0] observed, input logic [V-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, xx, yy;
        p = '0; xx = x; yy = y;
        for (int i = 0; i < 8; i++) begin
            if (yy[0]) p = p ^ xx;
            xx = xx[7] ? ((xx << 1) ^ 8'h1B) : (xx << 1);
            yy = yy >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sboxModel(input logic [7:0] x);
        logic [7:0] inv;
        inv = '0;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [V-1:0] modelAlu(input logic [2:0] o, input logic [V-1:0] a, input logic [V-1:0] b);
        logic [V-1:0] r;
        r = '0;
        case (o)
            3'd0: r = a ^ b;
            3'd1: for (int i = 0; i < V / 8; i++) r[i*8 +: 8] = 8'(a[i*8 +: 8] + b[i*8 +: 8]);
            3'd2: for (int i = 0; i < V / 8; i++) r[i*8 +: 8] = sboxModel(a[i*8 +: 8]);
            3'd3: for (int w = 0; w < V / 32; w++) r[w*32 +: 32] = {a[w*32 +: 24], a[w*32 + 24 +: 8]};
            3'd4: r = b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [V-1:0] randVec();
        logic [V-1:0] r;
        for (int w = 0; w < V / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void pushExp(input logic [V-1:0] res, input logic [R-1:0] w, input logic rw);
        exp_t e;
        e.result = res;
        e.wa     = w;
        e.rw     = rw;
        sb.push_back(e);
    endfunction

    task automatic applyStimulus(input logic s, input logic [2:0] o, input logic [V-1:0] aa,
                                 input logic [V-1:0] bb, input logic [R-1:0] w, input logic rw, input logic fl);
        bus_if.start    = s;
        bus_if.op       = o;
        bus_if.a        = aa;
        bus_if.b        = bb;
        bus_if.wa       = w;
        bus_if.regwrite = rw;
        bus_if.flush    = fl;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one VSUB and follows it until DONE, scrambling the E inputs while stalled.
    task automatic runVsub(input logic [V-1:0] aa, input logic [R-1:0] w, input logic rw, input logic hold,
                           output int stalls, output bit done, output logic [V-1:0] res);
        nextCycle();
        applyStimulus(1'b1, VSUB, aa, randVec(), w, rw, 1'b0);
        pushExp(modelAlu(3'd2, aa, '0), w, rw);
        @(negedge clk);
        stalls = bus_if.stall ? 1 : 0;
        checkOutput("vsub_start_valid", bus_if.valid, 1'b0);
        done = 1'b0;
        res  = '0;
        for (int i = 0; i < 20 && !done; i++) begin
            nextCycle();
            applyStimulus(hold, VSUB, randVec(), randVec(), w ^ 5'h1F, !rw, 1'b0);
            @(negedge clk);
            if (bus_if.valid) begin
                done = 1'b1;
                res  = bus_if.result;
                checkOutput("vsub_done_stall", bus_if.stall, 1'b0);
                checkOutput("vsub_done_wa", bus_if.wa_out, w);
            end else if (bus_if.stall) begin
                stalls++;
                checkOutput("vsub_run_wa", bus_if.wa_out, w);
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus_if.valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", bus_if.valid, 1'b0);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_result", bus_if.result, e.result);
                checkOutput("sb_wa", bus_if.wa_out, e.wa);
                checkOutput("sb_rw", bus_if.regwrite_out, e.rw);
            end
        end else begin
            checkOutput("idle_result", bus_if.result, '0);
            checkOutput("idle_rw", bus_if.regwrite_out, 1'b0);
        end
    end

    initial begin
        int           stalls;
        bit           done;
        logic [V-1:0] res, va, vb;
        logic [2:0]   o;
        int           r;

        applyStimulus(1'b0, VXOR, '0, '0, 5'h0A, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_stall", bus_if.stall, 1'b0);
        checkOutput("rst_valid", bus_if.valid, 1'b0);
        checkOutput("rst_result", bus_if.result, '0);
        checkOutput("rst_wa_out", bus_if.wa_out, 5'h0A);
        checkOutput("rst_regwrite", bus_if.regwrite_out, 1'b0);
        nextCycle();
        rst = 1'b0;

        nextCycle();
        applyStimulus(1'b1, VXOR, {32{8'hFF}}, {32{8'h0F}}, 5'h01, 1'b1, 1'b0);
        pushExp(modelAlu(3'd0, {32{8'hFF}}, {32{8'h0F}}), 5'h01, 1'b1);
        @(negedge clk);
        checkOutput("vxor_valid", bus_if.valid, 1'b1);
        checkOutput("vxor_stall", bus_if.stall, 1'b0);
        checkOutput("vxor_result", bus_if.result, {32{8'hF0}});

        nextCycle();
        applyStimulus(1'b1, VADD8, {32{8'hFF}}, {32{8'h01}}, 5'h02, 1'b0, 1'b0);
        pushExp(modelAlu(3'd1, {32{8'hFF}}, {32{8'h01}}), 5'h02, 1'b0);
        @(negedge clk);
        checkOutput("vadd8_wrap", bus_if.result, '0);

        nextCycle();
        applyStimulus(1'b1, VROT, {8{32'h01020304}}, '0, 5'h03, 1'b1, 1'b0);
        pushExp(modelAlu(3'd3, {8{32'h01020304}}, '0), 5'h03, 1'b1);
        @(negedge clk);
        checkOutput("vrot_result", bus_if.result, {8{32'h02030401}});

        nextCycle();
        va = randVec();
        applyStimulus(1'b1, 3'b101, va, randVec(), 5'h04, 1'b1, 1'b0);
        pushExp('0, 5'h04, 1'b1);
        @(negedge clk);
        checkOutput("reserved_valid", bus_if.valid, 1'b1);

        for (int i = 0; i < 10; i++) begin
            r  = $urandom_range(0, 6);
            o  = (r >= 2) ? 3'(r + 1) : 3'(r);
            va = randVec();
            vb = randVec();
            nextCycle();
            applyStimulus(1'b1, o, va, vb, 5'(i), 1'(i), 1'b0);
            pushExp(modelAlu(o, va, vb), 5'(i), 1'(i));
            @(negedge clk);
            checkOutput("rand_stall", bus_if.stall, 1'b0);
        end

        runVsub({248'h0, 8'h53}, 5'h11, 1'b1, 1'b1, stalls, done, res);
        checkOutput("vsub_done_seen", done, 1'b1);
        checkOutput("vsub_stall_cycles", stalls, 9);
        checkOutput("vsub_bytes", res, {{31{8'h63}}, 8'hED});

        nextCycle();
        va = randVec();
        vb = randVec();
        applyStimulus(1'b1, VXOR, va, vb, 5'h05, 1'b1, 1'b0);
        pushExp(modelAlu(3'd0, va, vb), 5'h05, 1'b1);
        @(negedge clk);
        checkOutput("b2b_valid", bus_if.valid, 1'b1);

        nextCycle();
        applyStimulus(1'b1, VSUB, randVec(), randVec(), 5'h06, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("flush_start_stall", bus_if.stall, 1'b0);
        checkOutput("flush_start_valid", bus_if.valid, 1'b0);
        nextCycle();
        applyStimulus(1'b1, VXOR, randVec(), randVec(), 5'h07, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("flush_nocapture_stall", bus_if.stall, 1'b0);
        checkOutput("flush_vxor_valid", bus_if.valid, 1'b0);

        nextCycle();
        applyStimulus(1'b1, VSUB, randVec(), randVec(), 5'h08, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("frun_start_stall", bus_if.stall, 1'b1);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(1'b0, VXOR, '0, '0, 5'h08, 1'b0, 1'b0);
            @(negedge clk);
        end
        nextCycle();
        bus_if.flush = 1'b1;
        @(negedge clk);
        checkOutput("frun_flush_stall", bus_if.stall, 1'b1);
        nextCycle();
        vb = randVec();
        applyStimulus(1'b1, VMOV, randVec(), vb, 5'h09, 1'b1, 1'b0);
        pushExp(vb, 5'h09, 1'b1);
        @(negedge clk);
        checkOutput("frun_after_stall", bus_if.stall, 1'b0);
        checkOutput("frun_after_valid", bus_if.valid, 1'b1);

        nextCycle();
        applyStimulus(1'b1, VSUB, randVec(), randVec(), 5'h0C, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            applyStimulus(1'b0, VXOR, '0, '0, 5'h0C, 1'b0, 1'b0);
        end
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rrun_stall", bus_if.stall, 1'b0);
        checkOutput("rrun_valid", bus_if.valid, 1'b0);
        checkOutput("rrun_result", bus_if.result, '0);

        va = randVec();
        runVsub(va, 5'h1A, 1'b0, 1'b0, stalls, done, res);
        checkOutput("rvsub_done_seen", done, 1'b1);
        checkOutput("rvsub_stall_cycles", stalls, 9);

        nextCycle();
        applyStimulus(1'b0, VXOR, '0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
